// File: rtl/core_seq_pkg.sv
// Shared definitions for the MAC-core instruction sequencer: FSM state codes,
// instruction-word bit positions, the idle instruction word and default sizes.
package core_seq_pkg;

   // Default array geometry and address/length widths
   localparam int ROW_DEF    = 8;
   localparam int COL_DEF    = 8;
   localparam int ADDR_W_DEF = 11;
   localparam int LEN_W_DEF  = 11;

   // FSM state codes, kept as plain constants for legacy tool compatibility
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WFETCH = 3'd1;
   localparam logic [2:0] ST_WLOAD  = 3'd2;
   localparam logic [2:0] ST_XFETCH = 3'd3;
   localparam logic [2:0] ST_EXEC   = 3'd4;
   localparam logic [2:0] ST_FLUSH  = 3'd5;
   localparam logic [2:0] ST_DRAIN  = 3'd6;
   localparam logic [2:0] ST_DONE   = 3'd7;

   // Instruction word bit positions (CEN/WEN are active-low)
   localparam int B_OUT_EN   = 35;
   localparam int B_MODE     = 34;
   localparam int B_ACC      = 33;
   localparam int B_CEN_P    = 32;
   localparam int B_WEN_P    = 31;
   localparam int B_PADDR_HI = 30;
   localparam int B_PADDR_LO = 20;
   localparam int B_CEN_X    = 19;
   localparam int B_WEN_X    = 18;
   localparam int B_XADDR_HI = 17;
   localparam int B_XADDR_LO = 7;
   localparam int B_OFIFO_RD = 6;
   localparam int B_IFIFO_WR = 5;
   localparam int B_IFIFO_RD = 4;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXECUTE  = 1;
   localparam int B_LOAD     = 0;

   // Both memories deselected, every strobe low
   localparam logic [35:0] IDLE_INST = 36'h1_800C_0000;

endpackage

// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for the MAC core. Steps one tile through weight fetch,
// array load, activation fetch, execute, flush and output drain, producing
// the 36-bit core instruction word each cycle.
module core_seq_ctrl
   import core_seq_pkg::*;
#(
   parameter int row    = ROW_DEF,
   parameter int col    = COL_DEF,
   parameter int addr_w = ADDR_W_DEF,
   parameter int len_w  = LEN_W_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cfg_mode,
   input  logic              cfg_acc,
   input  logic [addr_w-1:0] cfg_w_base,
   input  logic [addr_w-1:0] cfg_x_base,
   input  logic [addr_w-1:0] cfg_p_base,
   input  logic [len_w-1:0]  cfg_len,
   input  logic              ofifo_valid,
   output logic [35:0]       inst,
   output logic              busy,
   output logic              done
);

   // Phase counter must span both row+col and the vector count N
   localparam int PH_W = len_w + 1;
   localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};
   localparam logic [PH_W-1:0]  PH_ONE   = {{(PH_W-1){1'b0}}, 1'b1};
   localparam logic [PH_W-1:0]  PH_ROW   = PH_W'(row);
   localparam logic [PH_W-1:0]  PH_RC_M1 = PH_W'(row + col - 1);
   localparam logic [len_w-1:0] LEN_ZERO = {len_w{1'b0}};
   localparam logic [len_w-1:0] LEN_ONE  = {{(len_w-1){1'b0}}, 1'b1};

   logic [2:0]        state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [len_w-1:0]  out_cnt_q, out_cnt_d;
   logic              pend_q, pend_d;
   logic              busy_q, done_q;
   logic              mode_q, acc_q;
   logic [addr_w-1:0] w_base_q, x_base_q, p_base_q;
   logic [len_w-1:0]  len_q;
   logic              rd_s;
   logic [len_w:0]    issued_s;
   logic [35:0]       inst_s;

   assign issued_s = {1'b0, out_cnt_q} + {{len_w{1'b0}}, pend_q};

   // Next-state, phase counter and drain bookkeeping
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      out_cnt_d = out_cnt_q;
      pend_d    = pend_q;
      rd_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            phase_d   = PH_ZERO;
            out_cnt_d = LEN_ZERO;
            pend_d    = 1'b0;
            if (start) begin
               if (cfg_len != LEN_ZERO) begin
                  state_d = ST_WFETCH;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WFETCH: begin
            if (phase_q == PH_ROW) begin
               state_d = ST_WLOAD;
               phase_d = PH_ZERO;
            end else begin
               phase_d = phase_q + PH_ONE;
            end
         end
         ST_WLOAD: begin
            if (phase_q == PH_RC_M1) begin
               state_d = ST_XFETCH;
               phase_d = PH_ZERO;
            end else begin
               phase_d = phase_q + PH_ONE;
            end
         end
         ST_XFETCH: begin
            if (phase_q == {1'b0, len_q}) begin
               state_d = ST_EXEC;
               phase_d = PH_ZERO;
            end else begin
               phase_d = phase_q + PH_ONE;
            end
         end
         ST_EXEC: begin
            if (phase_q == ({1'b0, len_q} - PH_ONE)) begin
               state_d = ST_FLUSH;
               phase_d = PH_ZERO;
            end else begin
               phase_d = phase_q + PH_ONE;
            end
         end
         ST_FLUSH: begin
            if (phase_q == PH_RC_M1) begin
               state_d = ST_DRAIN;
               phase_d = PH_ZERO;
            end else begin
               phase_d = phase_q + PH_ONE;
            end
         end
         ST_DRAIN: begin
            // A read is only issued when data is present and more rows are owed
            rd_s   = ofifo_valid && (issued_s < {1'b0, len_q});
            pend_d = rd_s;
            if (pend_q) begin
               out_cnt_d = out_cnt_q + LEN_ONE;
               if ((out_cnt_q + LEN_ONE) == len_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DRAIN;
               end
            end else begin
               out_cnt_d = out_cnt_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         phase_q   <= PH_ZERO;
         out_cnt_q <= LEN_ZERO;
         pend_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         out_cnt_q <= out_cnt_d;
         pend_q    <= pend_d;
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_DONE);
      end
   end

   // Tile configuration captured on an accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= 1'b0;
         acc_q    <= 1'b0;
         w_base_q <= {addr_w{1'b0}};
         x_base_q <= {addr_w{1'b0}};
         p_base_q <= {addr_w{1'b0}};
         len_q    <= LEN_ZERO;
      end else if ((state_q == ST_IDLE) && start) begin
         mode_q   <= cfg_mode;
         acc_q    <= cfg_acc;
         w_base_q <= cfg_w_base;
         x_base_q <= cfg_x_base;
         p_base_q <= cfg_p_base;
         len_q    <= cfg_len;
      end else begin
         mode_q   <= mode_q;
         acc_q    <= acc_q;
         w_base_q <= w_base_q;
         x_base_q <= x_base_q;
         p_base_q <= p_base_q;
         len_q    <= len_q;
      end
   end

   // Instruction decode from registered state; only ofifo_rd follows ofifo_valid
   always_comb begin
      inst_s = IDLE_INST;
      if ((state_q != ST_IDLE) && (state_q != ST_DONE)) begin
         inst_s[B_MODE] = mode_q;
         inst_s[B_ACC]  = acc_q;
      end else begin
         inst_s[B_MODE] = 1'b0;
         inst_s[B_ACC]  = 1'b0;
      end
      case (state_q)
         ST_WFETCH: begin
            if (phase_q < PH_ROW) begin
               inst_s[B_CEN_X] = 1'b0;
               inst_s[B_XADDR_HI:B_XADDR_LO] = w_base_q + addr_w'(phase_q);
            end else begin
               inst_s[B_CEN_X] = 1'b1;
            end
            inst_s[B_L0_WR] = (phase_q != PH_ZERO);
         end
         ST_WLOAD: begin
            inst_s[B_L0_RD] = 1'b1;
            inst_s[B_LOAD]  = 1'b1;
         end
         ST_XFETCH: begin
            if (phase_q < {1'b0, len_q}) begin
               inst_s[B_CEN_X] = 1'b0;
               inst_s[B_XADDR_HI:B_XADDR_LO] = x_base_q + addr_w'(phase_q);
            end else begin
               inst_s[B_CEN_X] = 1'b1;
            end
            inst_s[B_L0_WR] = (phase_q != PH_ZERO);
         end
         ST_EXEC: begin
            inst_s[B_L0_RD]   = 1'b1;
            inst_s[B_EXECUTE] = 1'b1;
         end
         ST_FLUSH: begin
            inst_s[B_EXECUTE] = 1'b1;
         end
         ST_DRAIN: begin
            inst_s[B_OUT_EN]   = 1'b1;
            inst_s[B_OFIFO_RD] = rd_s;
            if (pend_q) begin
               inst_s[B_CEN_P] = 1'b0;
               inst_s[B_WEN_P] = 1'b0;
               inst_s[B_PADDR_HI:B_PADDR_LO] = p_base_q + addr_w'(out_cnt_q);
            end else begin
               inst_s[B_CEN_P] = 1'b1;
               inst_s[B_WEN_P] = 1'b1;
            end
         end
         default: begin
            inst_s = IDLE_INST;
         end
      endcase
   end

   assign inst = inst_s;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: builds the expected instruction stream
// of a whole tile from the phase lengths and a transaction-level drain model.
module tb_core_seq_ctrl;

   localparam int ROW = 8;
   localparam int COL = 8;
   localparam logic [35:0] IDLE_W = 36'h1_800C_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cfg_mode;
   logic        cfg_acc;
   logic [10:0] cfg_w_base;
   logic [10:0] cfg_x_base;
   logic [10:0] cfg_p_base;
   logic [10:0] cfg_len;
   logic        ofifo_valid;
   logic [35:0] inst;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   core_seq_ctrl dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_mode(cfg_mode), .cfg_acc(cfg_acc),
      .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base), .cfg_p_base(cfg_p_base),
      .cfg_len(cfg_len), .ofifo_valid(ofifo_valid),
      .inst(inst), .busy(busy), .done(done)
   );

   // Assemble an instruction word from named fields
   function automatic logic [35:0] mk(input logic m, input logic a, input logic oen,
                                      input logic cenp, input logic wenp, input logic [10:0] pa,
                                      input logic cenx, input logic [10:0] xa,
                                      input logic ofrd, input logic l0rd, input logic l0wr,
                                      input logic exe, input logic ld);
      logic [35:0] w;
      w = 36'h0;
      w[35] = oen;  w[34] = m;    w[33] = a;
      w[32] = cenp; w[31] = wenp; w[30:20] = pa;
      w[19] = cenx; w[18] = 1'b1; w[17:7] = xa;
      w[6] = ofrd;  w[3] = l0rd;  w[2] = l0wr; w[1] = exe; w[0] = ld;
      return w;
   endfunction

   // Valid pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random
   function automatic logic valid_at(input int pat, input int k);
      if (pat == 0) return 1'b1;
      if (pat == 1) return ((k % 3) == 0);
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic step(input logic v);
      @(negedge clk);
      start = 1'b0;
      ofifo_valid = v;
      #1;
   endtask

   task automatic launch(input logic m, input logic a, input logic [10:0] wb,
                         input logic [10:0] xb, input logic [10:0] pb, input logic [10:0] n);
      @(negedge clk);
      cfg_mode = m; cfg_acc = a; cfg_w_base = wb; cfg_x_base = xb;
      cfg_p_base = pb; cfg_len = n; start = 1'b1;
   endtask

   // Run one complete tile and check every cycle; inj_start pokes start mid-EXEC
   task automatic run_tile(input string nm, input logic m, input logic a,
                           input logic [10:0] wb, input logic [10:0] xb,
                           input logic [10:0] pb, input int n, input int pat,
                           input bit inj_start);
      logic [35:0] exp_q[$];
      logic [35:0] e;
      int rd, wr, k, idx, inj_at;
      logic pend, v, erd, ewr;
      exp_q.delete();
      for (int i = 0; i <= ROW; i++)
         exp_q.push_back(mk(m, a, 1'b0, 1'b1, 1'b1, 11'd0, (i < ROW) ? 1'b0 : 1'b1,
                            (i < ROW) ? 11'(wb + i) : 11'd0, 1'b0, 1'b0, (i >= 1), 1'b0, 1'b0));
      for (int i = 0; i < ROW + COL; i++)
         exp_q.push_back(mk(m, a, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i <= n; i++)
         exp_q.push_back(mk(m, a, 1'b0, 1'b1, 1'b1, 11'd0, (i < n) ? 1'b0 : 1'b1,
                            (i < n) ? 11'(xb + i) : 11'd0, 1'b0, 1'b0, (i >= 1), 1'b0, 1'b0));
      for (int i = 0; i < n; i++)
         exp_q.push_back(mk(m, a, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < ROW + COL; i++)
         exp_q.push_back(mk(m, a, 1'b0, 1'b1, 1'b1, 11'd0, 1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      inj_at = (ROW + 1) + (ROW + COL) + (n + 1) + ((n > 1) ? 1 : 0);

      launch(m, a, wb, xb, pb, 11'(n));
      idx = 0;
      foreach (exp_q[j]) begin
         step(valid_at(pat, idx));
         if (inj_start && idx == inj_at) begin
            start = 1'b1;
            cfg_mode = ~m; cfg_acc = ~a; cfg_len = 11'd0;
            cfg_w_base = 11'($urandom); cfg_x_base = 11'($urandom); cfg_p_base = 11'($urandom);
         end
         n_tests++;
         if (inst !== exp_q[j] || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s cycle %0d: inst=%h busy=%b done=%b, want inst=%h busy=1 done=0",
                     nm, idx, inst, busy, done, exp_q[j]);
         end
         idx++;
      end

      rd = 0; wr = 0; k = 0; pend = 1'b0;
      while (wr < n && k < 4000) begin
         v = valid_at(pat, k);
         step(v);
         erd = v && (rd < n);
         ewr = pend;
         e = mk(m, a, 1'b1, ~ewr, ~ewr, ewr ? 11'(pb + wr) : 11'd0, 1'b1, 11'd0,
                erd, 1'b0, 1'b0, 1'b0, 1'b0);
         n_tests++;
         if (inst !== e || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drain %0d: inst=%h busy=%b done=%b, want inst=%h",
                     nm, k, inst, busy, done, e);
         end
         if (ewr) wr++;
         if (erd) rd++;
         pend = erd;
         k++;
      end
      n_tests++;
      if (k >= 4000) begin
         n_fail++;
         $display("FAIL %s drain_timeout: writes=%0d, want %0d", nm, wr, n);
      end

      step(1'b0);
      n_tests++;
      if (inst !== IDLE_W || done !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done_cycle: inst=%h done=%b busy=%b, want %h 1 1", nm, inst, done, busy, IDLE_W);
      end
      step(1'b0);
      n_tests++;
      if (inst !== IDLE_W || done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_done: inst=%h done=%b busy=%b, want %h 0 0", nm, inst, done, busy, IDLE_W);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
      cfg_mode = 1'b0; cfg_acc = 1'b0; cfg_w_base = 11'd0; cfg_x_base = 11'd0;
      cfg_p_base = 11'd0; cfg_len = 11'd0;
      repeat (3) @(negedge clk);
      #1;
      n_tests++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: inst=%h busy=%b done=%b, want %h 0 0", inst, busy, done, IDLE_W);
      end
      @(negedge clk);
      reset = 1'b0;
      step(1'b0);
      n_tests++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: inst=%h busy=%b done=%b", inst, busy, done);
      end
   endtask

   task automatic test_zero_len();
      launch(1'b1, 1'b1, 11'd5, 11'd6, 11'd7, 11'd0);
      step(1'b1);
      n_tests++;
      if (done !== 1'b1 || inst !== IDLE_W) begin
         n_fail++;
         $display("FAIL zero_len_done: done=%b inst=%h, want 1 %h", done, inst, IDLE_W);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1);
         n_tests++;
         if (done !== 1'b0 || inst[32] !== 1'b1 || inst[19] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len_quiet: done=%b inst=%h, want done=0 CENs high", done, inst);
         end
      end
   endtask

   task automatic test_reset_mid_tile();
      int flush_at;
      flush_at = (ROW + 1) + (ROW + COL) + 5 + 4 + 3;
      launch(1'b0, 1'b1, 11'd0, 11'd16, 11'd0, 11'd4);
      for (int i = 0; i < flush_at; i++) step(1'b1);
      reset = 1'b1;
      step(1'b1);
      reset = 1'b0;
      n_tests++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: inst=%h busy=%b done=%b, want %h 0 0", inst, busy, done, IDLE_W);
      end
      for (int i = 0; i < 40; i++) begin
         step(1'b1);
         n_tests++;
         if (done !== 1'b0 || inst !== IDLE_W) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: done=%b inst=%h, want 0 %h", done, inst, IDLE_W);
         end
      end
   endtask

   initial begin
      test_reset();
      run_tile("ws_tile", 1'b0, 1'b0, 11'd0, 11'd16, 11'd0, 4, 0, 1'b0);
      run_tile("drain_stall", 1'b0, 1'b0, 11'd0, 11'd16, 11'd0, 4, 1, 1'b0);
      run_tile("pmem_wrap", 1'b1, 1'b1, 11'd0, 11'd16, 11'd2046, 4, 0, 1'b0);
      test_zero_len();
      run_tile("start_in_exec", 1'b1, 1'b0, 11'd100, 11'd200, 11'd300, 4, 0, 1'b1);
      test_reset_mid_tile();
      run_tile("after_reset", 1'b0, 1'b1, 11'd0, 11'd16, 11'd0, 4, 0, 1'b0);
      for (int r = 0; r < 4; r++)
         run_tile("random", 1'($urandom), 1'($urandom), 11'($urandom), 11'($urandom),
                  11'($urandom), $urandom_range(1, 7), 2, 1'($urandom));
      run_tile("addr_wrap", 1'b0, 1'b0, 11'd2044, 11'd2045, 11'd2047, 3, 2, 1'b0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
